// File: rtl/lightpipe_pkg.sv
// Shared constants, FSM state type and frame-length helper for the ADAT/Lightpipe deframer.
package lightpipe_pkg;

    localparam int SYNC_ZEROS       = 10;
    localparam int NIBBLE_BITS      = 4;
    localparam int NIBBLES_PER_CHAN = 6;
    localparam int CHAN_CELL_BITS   = 30;
    localparam int USER_BITS        = 4;

    typedef enum logic [2:0] {
        HUNT,
        USER,
        DATA,
        COMMIT,
        ERR
    } state_t;

    function automatic int frame_bits(input int n);
        return 16 + CHAN_CELL_BITS * n;
    endfunction

endpackage

// File: rtl/lightpipe_bit_slicer.sv
// NRZI bit recovery: 2-flop synchroniser, edge detector and mid-cell sampling phase counter.
module lightpipe_bit_slicer #(
    parameter int OVERSAMPLE = 8
) (
    input  logic rclk,
    input  logic rst,
    input  logic adat,
    output logic bit_stb,
    output logic bit_val
);

    localparam int            PW       = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] STB_PH   = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(OVERSAMPLE - 1);

    logic          adat_p0, adat_p1, adat_p2;
    logic [PW-1:0] phase;
    logic          seen;
    logic          line_edge;

    assign line_edge = adat_p1 ^ adat_p2;

    always_ff @(posedge rclk) begin
        if (rst) begin
            adat_p0 <= 1'b0;
            adat_p1 <= 1'b0;
            adat_p2 <= 1'b0;
            phase   <= '0;
            seen    <= 1'b0;
            bit_stb <= 1'b0;
            bit_val <= 1'b0;
        end else begin
            // stage boundary: p0/p1 synchronise, p2 delays for edge detect
            adat_p0 <= adat;
            adat_p1 <= adat_p0;
            adat_p2 <= adat_p1;
            bit_stb <= 1'b0;
            if (line_edge) begin
                phase <= '0;
                seen  <= 1'b1;
            end else begin
                phase <= (phase == LAST_PH) ? '0 : phase + PW'(1);
                if (phase == STB_PH) begin
                    bit_stb <= 1'b1;
                    bit_val <= seen;
                    seen    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/lightpipe_deframer.sv
// ADAT/Lightpipe frame receiver: sync hunt, user/sample extraction, atomic frame publish, lock tracking.
// Optional LIGHTPIPE_ERRCNT_EN adds a saturating frame-error counter output err_count.
module lightpipe_deframer
    import lightpipe_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int SAMPLE_WIDTH = 24,
    parameter int OVERSAMPLE   = 8,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic                                 rclk,
    input  logic                                 rst,
    input  logic                                 adat,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] chan_data,
    output logic [3:0]                           user,
    output logic                                 frame_valid,
    output logic                                 frame_err,
    output logic                                 locked
`ifdef LIGHTPIPE_ERRCNT_EN
    ,
    output logic [15:0]                          err_count
`endif
);

    localparam int            CW        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHANNELS - 1);
    localparam int            LW        = $clog2(LOCK_FRAMES + 1);
    localparam logic [LW-1:0] LOCK_N    = LW'(LOCK_FRAMES);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [LW-1:0] sat_lock(input logic [LW-1:0] v);
        return (v == LOCK_N) ? v : v + LW'(1);
    endfunction

    logic bit_stb, bit_val;

    lightpipe_bit_slicer #(.OVERSAMPLE(OVERSAMPLE)) u_slicer (
        .rclk    (rclk),
        .rst     (rst),
        .adat    (adat),
        .bit_stb (bit_stb),
        .bit_val (bit_val)
    );

    logic [3:0] zero_run;
    logic       sync_hit;

    assign sync_hit = bit_stb && bit_val && (zero_run >= 4'(SYNC_ZEROS));

    always_ff @(posedge rclk) begin
        if (rst)
            zero_run <= '0;
        else if (bit_stb)
            zero_run <= bit_val ? 4'd0 : sat_inc4(zero_run);
    end

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [2:0]    nib_cnt, nib_cnt_nxt;
    logic [CW-1:0] chan_cnt, chan_cnt_nxt;
    logic          commit_now, err_now, shift_user, shift_data;

    always_ff @(posedge rclk) begin
        if (rst) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            nib_cnt  <= '0;
            chan_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            nib_cnt  <= nib_cnt_nxt;
            chan_cnt <= chan_cnt_nxt;
        end
    end

    // A sync marker inside a frame restarts the user field immediately so the new frame is kept
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        nib_cnt_nxt  = nib_cnt;
        chan_cnt_nxt = chan_cnt;
        commit_now   = 1'b0;
        err_now      = 1'b0;
        shift_user   = 1'b0;
        shift_data   = 1'b0;
        case (state)
            HUNT: begin
                if (sync_hit) begin
                    state_nxt   = USER;
                    bit_cnt_nxt = '0;
                end
            end
            USER, DATA: begin
                if (sync_hit) begin
                    err_now     = 1'b1;
                    state_nxt   = USER;
                    bit_cnt_nxt = '0;
                end else if (bit_stb && state == USER) begin
                    if (bit_cnt == 3'(USER_BITS)) begin
                        if (bit_val) begin
                            state_nxt    = DATA;
                            bit_cnt_nxt  = '0;
                            nib_cnt_nxt  = '0;
                            chan_cnt_nxt = '0;
                        end else begin
                            state_nxt = ERR;
                            err_now   = 1'b1;
                        end
                    end else begin
                        shift_user  = 1'b1;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else if (bit_stb) begin
                    if (bit_cnt == 3'(NIBBLE_BITS)) begin
                        if (!bit_val) begin
                            state_nxt = ERR;
                            err_now   = 1'b1;
                        end else begin
                            bit_cnt_nxt = '0;
                            if (nib_cnt == 3'(NIBBLES_PER_CHAN - 1)) begin
                                nib_cnt_nxt = '0;
                                if (chan_cnt == LAST_CHAN) begin
                                    state_nxt  = COMMIT;
                                    commit_now = 1'b1;
                                end else begin
                                    chan_cnt_nxt = chan_cnt + CW'(1);
                                end
                            end else begin
                                nib_cnt_nxt = nib_cnt + 3'd1;
                            end
                        end
                    end else begin
                        shift_data  = 1'b1;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            COMMIT:  state_nxt = HUNT;
            ERR:     state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    logic [23:0] shadow [NUM_CHANNELS];
    logic [3:0]  user_sh;

    always_ff @(posedge rclk) begin
        if (shift_user)
            user_sh <= {user_sh[2:0], bit_val};
        if (shift_data)
            shadow[chan_cnt] <= {shadow[chan_cnt][22:0], bit_val};
    end

    logic [LW-1:0] good_cnt;
    logic [LW-1:0] good_inc;

    assign good_inc = sat_lock(good_cnt);

    // stage boundary: outputs are loaded on the edge that enters COMMIT, alongside the strobe
    always_ff @(posedge rclk) begin
        if (rst) begin
            chan_data   <= '0;
            user        <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
            good_cnt    <= '0;
        end else begin
            frame_valid <= commit_now;
            frame_err   <= err_now;
            if (commit_now) begin
                for (int k = 0; k < NUM_CHANNELS; k++)
                    chan_data[SAMPLE_WIDTH*k +: SAMPLE_WIDTH] <= shadow[k][23 -: SAMPLE_WIDTH];
                user     <= user_sh;
                good_cnt <= good_inc;
                locked   <= (good_inc == LOCK_N);
            end else if (err_now) begin
                good_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end

`ifdef LIGHTPIPE_ERRCNT_EN
    always_ff @(posedge rclk) begin
        if (rst)
            err_count <= '0;
        else if (err_now && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule
